nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle 32-bit subtractor for the ARITH unit that computes `a - b` four bits per clock. It uses the same 4-bit carry-skip nibble slice as the adder path, fed with inverted `b` and carry-in 1, and walks nibbles 0..7 under a start/done handshake. It is the subtract-direction counterpart to the nibble adder path, for area-constrained ARITH builds. It also produces Beta-style condition flags for SUB/CMP instructions.

## Interface

- `WIDTH`, 32: operand width; must be a multiple of 4; nibble count `NIB = WIDTH/4`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset, sampled on `clk` rising edge.
- `start` input 1: request; accepted only in IDLE or DONE.
- `a` input WIDTH: minuend; captured when `start` is accepted.
- `b` input WIDTH: subtrahend; captured when `start` is accepted.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; results valid.
- `diff` output WIDTH: `a - b` modulo 2^WIDTH.
- `c` output 1: final carry-out; 1 means no borrow (`a >= b` unsigned).
- `z` output 1: `diff == 0`.
- `n` output 1: `diff[WIDTH-1]`.
- `v` output 1: signed overflow.
- `cmpeq`, `cmplt`, `cmple` output 1 each: present only with `NSS_CMP_EN`.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE or DONE, `start=1`:**
  - Capture `a` into `ra`.
  - Capture `~b` into `rb`.
  - Set `sign_b = b[WIDTH-1]`.
  - Set `carry = 1`, `idx = 0`.
  - Clear `diff`.
  - Go to RUN.
- **IDLE, `start=0`:** hold state and all outputs.
- **DONE, `start=0`:** go to IDLE.
- **RUN, each cycle:**
  - Compute `{co, s} = ra[idx*4+:4] + rb[idx*4+:4] + carry` through the carry-skip nibble slice.
  - Write `s` into `diff[idx*4+:4]`.
  - Set `carry <= co` and `idx <= idx + 1`.
  - When `idx == NIB-1`, go to DONE.
- **`start` in RUN:** ignored, with no effect on operands or progress.
- **Flags and compares:** registered on the RUN-to-DONE transition from the final nibble.
  - `c` = final carry.
  - `z` = all bits of `diff` are 0, including the last nibble.
  - `n` = `diff` MSB.
  - `v` = `(ra[MSB] != sign_b) && (diff[MSB] != ra[MSB])`.
- **Output hold:** `diff`, `c`, `z`, `n`, `v` and the compares hold from DONE until the next accepted `start`.
  - `diff` shows partial results while in RUN.
  - Consumers sample only on `done`.
- **Reset values:** all outputs are 0 (`busy`, `done`, `diff`, `c`, `z`, `n`, `v`, compares). Internal registers are 0 and the state is IDLE.
- **Reset mid-operation:** abort at the next edge. State goes to IDLE, outputs go to reset values, and no `done` pulse is produced.
- **Reset and `start` in the same cycle:** reset wins.

## Timing

- Let the accept edge be E0, where `start=1` is sampled in IDLE or DONE.
- RUN spans E0 to E8. Nibble k is written at edge E(k+1), k = 0..7.
- After E8: state is DONE, `done=1`, `busy=0`, results valid.
- After E9: `done=0`.
- Latency: 9 cycles from accept to `done`, with `WIDTH=32`. In general it is `NIB+1` cycles.
- Back-to-back: `start=1` during the DONE cycle is accepted at E9 and the next `done` comes after E17. Throughput is one result per `NIB+1` cycles.
- `busy` is high for exactly `NIB` cycles per operation.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration

- `NSS_CMP_EN` defined:
  - Adds the `cmpeq`, `cmplt` and `cmple` ports.
  - `cmpeq = z`.
  - `cmplt = n ^ v`.
  - `cmple = z | (n ^ v)`.
  - Registered with the other flags; reset to 0.
- `NSS_CMP_EN` undefined:
  - The ports and their logic are absent.
  - All other behaviour is identical.

## Test plan

- `a=0x00000005`, `b=0x00000002`, start pulse -> after 9 cycles `done` = 1 for exactly 1 cycle; `diff=0x00000003`, `c=1`, `z=0`, `n=0`, `v=0`; `busy` high for 8 cycles.
- `a=0x00000004`, `b=0x00000004` -> `diff=0`, `z=1`, `c=1`; with `NSS_CMP_EN`: `cmpeq=1`, `cmplt=0`, `cmple=1`.
- `a=0x00000002`, `b=0x00000005` -> `diff=0xFFFFFFFD`, `n=1`, `c=0`, `v=0`; with `NSS_CMP_EN`: `cmplt=1`.
- `a=0x80000000`, `b=0x00000001` -> `diff=0x7FFFFFFF`, `v=1`, `n=0`, `c=1`; with `NSS_CMP_EN`: `cmplt=1`. Then `a=0x7FFFFFFF`, `b=0xFFFFFFFF` -> `diff=0x80000000`, `v=1`.
- Handshake:
  - Start A; pulse `start` with different operands in RUN cycle 3 -> ignored, result equals A's.
  - Assert `start` during A's DONE cycle with B -> B accepted, B's `done` exactly 9 cycles after A's.
- Reset: `reset=1` in RUN cycle 4 -> next cycle `busy=0`, `diff=0`, all flags 0; no `done` pulse in the following 12 cycles; a new start then completes normally.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//   Multi-cycle a - b, four bits per clock. Each cycle one nibble of a and
//   one nibble of the inverted subtrahend go through a 4-bit carry-skip
//   slice. The carry chain is seeded with 1, which gives two's complement
//   subtraction. Condition flags (c, z, n, v) are registered when the last
//   nibble is written.
//   Optional feature: define NSS_CMP_EN to add the cmpeq/cmplt/cmple ports.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for start; outputs hold the last result
//   ST_RUN    | one nibble per cycle, idx 0..NIB-1
//   ST_DONE   | one-cycle done pulse; start here is accepted back-to-back

module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v
`ifdef NSS_CMP_EN
    ,
    output logic             cmpeq,
    output logic             cmplt,
    output logic             cmple
`endif
);

    // WIDTH must be a multiple of 4.
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             sign_b_q, sign_b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;
`ifdef NSS_CMP_EN
    logic             cmpeq_q, cmpeq_d;
    logic             cmplt_q, cmplt_d;
    logic             cmple_q, cmple_d;
`endif

    logic [3:0]       nib_x;
    logic [3:0]       nib_y;
    logic [3:0]       nib_s;
    logic             nib_co;
    logic             accept;

    // 4-bit carry-skip slice: ripple inside the nibble, but when every bit
    // propagates the carry-out is taken straight from the carry-in.
    function automatic logic [4:0] cskip_nibble(input logic [3:0] x,
                                                input logic [3:0] y,
                                                input logic       ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] cc;
        logic [3:0] s;
        logic       co;
        p     = x ^ y;
        g     = x & y;
        cc[0] = ci;
        for (int i = 0; i < 4; i++) begin
            cc[i+1] = g[i] | (p[i] & cc[i]);
        end
        s  = p ^ cc[3:0];
        co = (&p) ? ci : cc[4];
        return {co, s};
    endfunction

    // Select the current operand nibbles and run them through the slice.
    always_comb begin
        nib_x = ra_q[idx_q*4 +: 4];
        nib_y = rb_q[idx_q*4 +: 4];
        {nib_co, nib_s} = cskip_nibble(nib_x, nib_y, carry_q);
    end

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, datapath update and flag capture.
    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        sign_b_d = sign_b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
`ifdef NSS_CMP_EN
        cmpeq_d  = cmpeq_q;
        cmplt_d  = cmplt_q;
        cmple_d  = cmple_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    ra_d     = a;
                    rb_d     = ~b;
                    sign_b_d = b[MSB];
                    carry_d  = 1'b1;
                    idx_d    = '0;
                    diff_d   = '0;
                    state_d  = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d  = ST_IDLE;
                end
            end

            ST_RUN: begin
                diff_d[idx_q*4 +: 4] = nib_s;
                carry_d              = nib_co;
                idx_d                = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    // Flags come from diff_d so the final nibble is included.
                    c_d     = nib_co;
                    z_d     = (diff_d == '0);
                    n_d     = diff_d[MSB];
                    v_d     = (ra_q[MSB] != sign_b_q) && (diff_d[MSB] != ra_q[MSB]);
`ifdef NSS_CMP_EN
                    cmpeq_d = z_d;
                    cmplt_d = n_d ^ v_d;
                    cmple_d = z_d | (n_d ^ v_d);
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            sign_b_q <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
`ifdef NSS_CMP_EN
            cmpeq_q  <= 1'b0;
            cmplt_q  <= 1'b0;
            cmple_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            sign_b_q <= sign_b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
`ifdef NSS_CMP_EN
            cmpeq_q  <= cmpeq_d;
            cmplt_q  <= cmplt_d;
            cmple_q  <= cmple_d;
`endif
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign diff  = diff_q;
    assign c     = c_q;
    assign z     = z_q;
    assign n     = n_q;
    assign v     = v_q;
`ifdef NSS_CMP_EN
    assign cmpeq = cmpeq_q;
    assign cmplt = cmplt_q;
    assign cmple = cmple_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor
//   Directed vectors with hand-computed results; expected results go into a
//   scoreboard queue at issue time and a monitor pops them on each done.
//   Honours NSS_CMP_EN like the design.

module tb_nibble_serial_subtractor;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        c, z, n, v;
`ifdef NSS_CMP_EN
    logic        cmpeq, cmplt, cmple;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    exp_t sb_q[$];

    nibble_serial_subtractor #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .c     (c),
        .z     (z),
        .n     (n),
        .v     (v)
`ifdef NSS_CMP_EN
        ,
        .cmpeq (cmpeq),
        .cmplt (cmplt),
        .cmple (cmple)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 diff=%h", diff);
            end else begin
                e = sb_q.pop_front();
                check("diff", diff, e.d);
                check("c", {31'd0, c}, {31'd0, e.c});
                check("z", {31'd0, z}, {31'd0, e.z});
                check("n", {31'd0, n}, {31'd0, e.n});
                check("v", {31'd0, v}, {31'd0, e.v});
`ifdef NSS_CMP_EN
                check("cmpeq", {31'd0, cmpeq}, {31'd0, e.z});
                check("cmplt", {31'd0, cmplt}, {31'd0, e.n ^ e.v});
                check("cmple", {31'd0, cmple}, {31'd0, e.z | (e.n ^ e.v)});
`endif
            end
        end
    end

    // Drive start for one edge; returns #1 after the accept edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input bit push, input exp_t e);
        @(posedge clk);
        #1;
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts negedge samples until done (bounded), and busy samples seen.
    task automatic wait_done(input string name, output int samples, output int busy_cnt);
        samples  = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            samples++;
            if (busy) busy_cnt++;
        end while (!done && samples < 40);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic cc, input logic zz,
                                input logic nn, input logic vv);
        exp_t e;
        e.d = d; e.c = cc; e.z = zz; e.n = nn; e.v = vv;
        return e;
    endfunction

    localparam int NV = 9;
    logic [31:0] va [NV] = '{32'h0000_0005, 32'h0000_0004, 32'h0000_0002, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_0000,
                             32'hFFFF_FFFF};
    logic [31:0] vb [NV] = '{32'h0000_0002, 32'h0000_0004, 32'h0000_0005, 32'h0000_0001,
                             32'hFFFF_FFFF, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0000_0001,
                             32'h0000_0000};
    exp_t ve [NV];

    initial begin
        int   s, bc, dcnt;
        exp_t none;
        none = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        ve[0] = mk(32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b0);
        ve[1] = mk(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        ve[2] = mk(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 1'b0);
        ve[3] = mk(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        ve[4] = mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        ve[5] = mk(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        ve[6] = mk(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        ve[7] = mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        ve[8] = mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);

        reset = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_flags", {28'd0, c, z, n, v}, 32'd0);
        reset = 1'b0;

        // Directed vectors, one at a time.
        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], 1'b1, ve[i]);
            wait_done("vec", s, bc);
            check("latency", s, 32'd9);
            check("busy_cycles", bc, 32'd8);
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd0);
        end

        // start during RUN is ignored.
        issue(32'h0000_0100, 32'h0000_0001, 1'b1, mk(32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        a_i   = 32'h1234_5678;
        b_i   = 32'h0000_0008;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", s, bc);
        check("ignore_latency", s, 32'd7);

        // Back-to-back: start in A's DONE cycle.
        a_i   = 32'h0000_0010;
        b_i   = 32'h0000_0001;
        start = 1'b1;
        sb_q.push_back(mk(32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b", s, bc);
        check("b2b_spacing", s, 32'd9);
        @(negedge clk);

        // Reset in the middle of an operation.
        issue(32'h0000_0009, 32'h0000_0003, 1'b0, none);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", diff, 32'd0);
        check("abort_flags", {28'd0, c, z, n, v}, 32'd0);
        reset = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 32'd0);

        issue(32'h8000_0000, 32'h0000_0001, 1'b1, ve[3]);
        wait_done("post_reset", s, bc);
        check("post_reset_latency", s, 32'd9);
        repeat (3) @(negedge clk);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
